data_mem_ctrl: RTL and testbench

- Parametrised next-generation data memory for the processor datapath.
- Replaces the combinational-read, tri-state output RAM with a handshaked controller:
  - synchronous req/done protocol;
  - programmable access latency;
  - registered, held read data (never Z);
  - hardware zero-fill after reset;
  - out-of-range address detection.
- Sits between the core's load/store stage and the memory array. The core stalls on Ready=0.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 27 ++
 rtl/data_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } dmem_state_t;

  localparam int DMEM_DW      = 8;
  localparam int DMEM_AW      = 8;
  localparam int DMEM_LATENCY = 1;

  // Counter/pointer width: ceil(log2(n)), but never narrower than one bit.
  function automatic int dmem_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DW x DEPTH storage: synchronous write, asynchronous read.
// Latency: write lands on the clock edge, read data follows addr combinationally.
// Backpressure: none; the controller decides when we is allowed.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int DEPTH = 2 ** DMEM_AW,
  parameter int IW    = dmem_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write port; contents are not reset, the controller zero-fills them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data memory controller: zero-fill after reset, programmable access latency.
// Latency: accept at edge k, access at edge k+LATENCY, Done high the following cycle.
// Backpressure: Ready=0 during zero-fill and while an access is in flight; Req is then ignored.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DW      = DMEM_DW,
  parameter int AW      = DMEM_AW,
  parameter int DEPTH   = 2 ** AW,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req,
  input  logic          WriteEn,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] DataIn,
  output logic          Ready,
  output logic          Done,
  output logic [DW-1:0] DataOut,
  output logic          AddrErr
);

  localparam int IW = dmem_clog2(DEPTH);
  localparam int CW = dmem_clog2(LATENCY);

  dmem_state_t state, state_nxt;

  logic [IW-1:0] clr_ptr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [DW-1:0] req_data;

  logic          req_oob;
  logic          last_clr;
  logic          cnt_zero;

  logic          arr_we;
  logic [IW-1:0] arr_addr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  // A full-size array has no illegal addresses, so the range check folds away.
  generate
    if (DEPTH == 2 ** AW) begin : g_full
      assign req_oob = 1'b0;
    end else begin : g_partial
      assign req_oob = (req_addr >= AW'(DEPTH));
    end
  endgenerate

  assign last_clr = (clr_ptr == IW'(DEPTH - 1));
  assign cnt_zero = (cnt == '0);

  // State register; reset always restarts the zero-fill.
  always_ff @(posedge CLK) begin
    if (Reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next-state: CLEAR -> IDLE after the last entry, IDLE -> BUSY on Req, BUSY -> IDLE when cnt expires.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (last_clr) state_nxt = IDLE;
      IDLE:    if (Req)      state_nxt = BUSY;
      BUSY:    if (cnt_zero) state_nxt = IDLE;
      default:               state_nxt = CLEAR;
    endcase
  end

  // Outputs and array port mux: zero-fill writes in CLEAR, latched request in BUSY.
  // Reset gates the write so an in-flight store is never committed on the reset edge.
  always_comb begin
    Ready     = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = req_addr[IW-1:0];
    arr_wdata = req_data;
    case (state)
      CLEAR: begin
        arr_we    = ~Reset;
        arr_addr  = clr_ptr;
        arr_wdata = '0;
      end
      IDLE: begin
        Ready = 1'b1;
      end
      BUSY: begin
        arr_we = ~Reset & cnt_zero & req_we & ~req_oob;
      end
      default: begin
        Ready = 1'b0;
      end
    endcase
  end

  // Datapath: fill pointer, request latch, latency counter, completion pulses and read register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      clr_ptr  <= '0;
      cnt      <= '0;
      req_addr <= '0;
      req_we   <= 1'b0;
      req_data <= '0;
      Done     <= 1'b0;
      AddrErr  <= 1'b0;
      DataOut  <= '0;
    end else begin
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= last_clr ? '0 : clr_ptr + 1'b1;
        end
        IDLE: begin
          if (Req) begin
            req_addr <= Addr;
            req_we   <= WriteEn;
            req_data <= DataIn;
            cnt      <= CW'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            Done    <= 1'b1;
            AddrErr <= req_oob;
            if (!req_we) DataOut <= req_oob ? '0 : arr_rdata;
          end
        end
        default: begin
          clr_ptr <= '0;
        end
      endcase
    end
  end

  dmem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (partial depth / latency 3, full depth / latency 1).
// Stimulus queues the expected completion; a negedge monitor pops and compares on each Done.
// Latency, accept spacing, zero-fill length and reset behaviour are checked by the stimulus.
module tb_data_mem_ctrl;

  localparam int LAT_A   = 3;
  localparam int DEPTH_A = 200;
  localparam int LAT_B   = 1;
  localparam int DEPTH_B = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req   [2];
  logic       we    [2];
  logic [7:0] addr  [2];
  logic [7:0] din   [2];
  logic       ready [2];
  logic       done  [2];
  logic       aerr  [2];
  logic [7:0] dout  [2];

  typedef struct {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DW(8), .AW(8), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .CLK(clk), .Reset(rst), .Req(req[0]), .WriteEn(we[0]), .Addr(addr[0]), .DataIn(din[0]),
    .Ready(ready[0]), .Done(done[0]), .DataOut(dout[0]), .AddrErr(aerr[0])
  );

  data_mem_ctrl #(.DW(8), .AW(8), .DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .CLK(clk), .Reset(rst), .Req(req[1]), .WriteEn(we[1]), .Addr(addr[1]), .DataIn(din[1]),
    .Ready(ready[1]), .Done(done[1]), .DataOut(dout[1]), .AddrErr(aerr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event, required one (t=%0t)", name, $time);
  endtask

  task automatic push(input int d, input logic [7:0] ed, input logic ee);
    exp_t e;
    e.dout = ed;
    e.err  = ee;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard monitor: every Done must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int   sz;
      if (aerr[d]) check($sformatf("aerr_needs_done_%0d", d), done[d], 1);
      if (done[d]) begin
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          fail($sformatf("unexpected_done_%0d", d));
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("dout_%0d", d), dout[d], e.dout);
          check($sformatf("aerr_%0d", d), aerr[d], e.err);
        end
      end
    end
  end

  // Called at a negedge; returns at the first negedge where Ready is high.
  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ready[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail($sformatf("ready_timeout_%0d", d));
  endtask

  // One access; inputs are scrambled right after acceptance to prove they were latched.
  task automatic access(input int d, input bit wr, input logic [7:0] a, input logic [7:0] di,
                        input logic [7:0] ed, input logic ee);
    bit ok;
    int n;
    int lat;
    wait_ready(d, ok);
    if (!ok) return;
    req[d]  = 1'b1;
    we[d]   = wr;
    addr[d] = a;
    din[d]  = di;
    push(d, ed, ee);
    @(posedge clk);
    #1;
    req[d]  = 1'b0;
    we[d]   = ~wr;
    addr[d] = 8'hEE;
    din[d]  = ~di;
    lat = (d == 0) ? LAT_A : LAT_B;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[d] !== 1'b1 && n < 100);
    check($sformatf("latency_%0d_addr_%0h", d, a), n, lat + 1);
  endtask

  // Counts Ready-low negedges, starting at the negedge where reset drops.
  task automatic count_clear(input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 400; i++) begin
      if (ready[0] !== 1'b1) na++;
      if (ready[1] !== 1'b1) nb++;
      @(negedge clk);
    end
    check("clear_cycles_a", na, exp_a);
    check("clear_cycles_b", nb, exp_b);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_done_%0d", d), done[d], 0);
      check($sformatf("rst_aerr_%0d", d), aerr[d], 0);
      check($sformatf("rst_dout_%0d", d), dout[d], 0);
      check($sformatf("rst_ready_%0d", d), ready[d], 0);
    end
    count_clear(DEPTH_A, DEPTH_B);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    bit         bw [6];
    logic [7:0] ba [6];
    logic [7:0] bd [6];
    logic [7:0] be [6];
    int         last;
    int         n;

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; din[d] = '0;
    end
    @(negedge clk);

    // Zero-fill length and reset state, then reads of cleared words.
    pulse_reset();
    access(1, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0);
    access(1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
    access(1, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0);
    access(1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0);

    // Latency 3: write leaves DataOut alone, read returns the new word.
    access(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    access(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

    // Req held high, alternating addresses; inputs scrambled while busy.
    bw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ba = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
    bd = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    be = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h11, 8'h22};
    last = 0;
    for (int i = 0; i < 6; i++) begin
      wait_ready(0, ok);
      if (!ok) break;
      req[0]  = 1'b1;
      we[0]   = bw[i];
      addr[0] = ba[i];
      din[0]  = bd[i];
      push(0, be[i], 1'b0);
      if (i > 0) check("accept_interval", cyc - last, LAT_A + 1);
      last = cyc;
      @(negedge clk);
      we[0]   = ~bw[i];
      addr[0] = ba[i] ^ 8'h03;
      din[0]  = 8'hEE;
    end
    req[0] = 1'b0;
    n = 0;
    while (q0.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drained", q0.size(), 0);

    // Out of range on the 200-deep instance.
    access(0, 1'b1, 8'hC8, 8'hFF, 8'h22, 1'b1);
    access(0, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1);
    access(0, 1'b0, 8'hC7, 8'h00, 8'h00, 1'b0);
    access(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

    // DataOut holds across a write completion.
    access(0, 1'b1, 8'h30, 8'h3C, 8'hA5, 1'b0);
    access(0, 1'b0, 8'h30, 8'h00, 8'h3C, 1'b0);
    access(0, 1'b1, 8'h30, 8'h99, 8'h3C, 1'b0);
    access(0, 1'b0, 8'h30, 8'h00, 8'h99, 1'b0);

    // Reset two cycles after accepting a write: no Done, no commit, fill re-runs.
    wait_ready(0, ok);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; din[0] = 8'h55;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_dout_a", dout[0], 0);
    check("midrst_dout_b", dout[1], 0);
    check("midrst_ready_a", ready[0], 0);
    count_clear(DEPTH_A, DEPTH_B);
    access(0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
    access(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
    access(1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_a_empty", q0.size(), 0);
    check("queue_b_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
